// File: rtl/uart_tx_serializer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_serializer_pkg : shared state encoding, bit-period helper, defaults
// Revision: 1.0
// ---------------------------------------------------------------------------
package uart_tx_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    localparam int FIFO_DEPTH_DEFAULT = 16;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_fifo : single-clock synchronous word buffer with full/empty flags
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    // A read in the same cycle frees a slot, so a write to a full buffer still lands
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_serializer : buffers 16-bit big-endian words, sends bytes as UART.
// Optional macro UART_PARITY_EN adds an even/odd parity bit (8P1 vs 8N1).
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int CLK_FREQ   = 48000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DATA,
    input  logic        ENA,
    input  logic [7:0]  MSG_LEN_IN,
    input  logic        PARITY_IN,
    output logic        TX,
    output logic        BUSY,
    output logic        OVF
);
    localparam int            DIV       = calc_div(CLK_FREQ, BAUD);
    localparam int            BW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    state_t        state;
    state_t        state_nx;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    low_byte;
    logic [7:0]    words_left;
    logic          have_low;
    logic          len_odd;
    logic          ovf_q;

    logic          tick;
    logic          first_word;
    logic          more_word;
    logic          fifo_wr;
    logic          fifo_rd;
    logic          fifo_full;
    logic          fifo_empty;
    logic [16:0]   fifo_wdata;
    logic [16:0]   fifo_rdata;
    logic          load;
    logic [7:0]    load_byte;
    logic          bytes_pending;
    logic          par_bit;

    assign tick       = (baud_cnt == BAUD_LAST);
    assign first_word = (state == ST_IDLE) && ENA && (MSG_LEN_IN != 8'd0);
    assign more_word  = (state != ST_IDLE) && ENA && (words_left != 8'd0);
    assign fifo_wr    = (first_word || more_word) && (!fifo_full || fifo_rd);
    // Bit 16 tags the final word of an odd-length message: only its high byte is sent
    assign fifo_wdata = {first_word ? (MSG_LEN_IN == 8'd1) : (len_odd && (words_left == 8'd1)), DATA};
    assign bytes_pending = have_low || !fifo_empty || (words_left != 8'd0);
    assign BUSY = (state != ST_IDLE);
    assign OVF  = ovf_q;

    uart_tx_fifo #(
        .WIDTH (17),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_nx  = state;
        fifo_rd   = 1'b0;
        load      = 1'b0;
        load_byte = low_byte;
        case (state)
            ST_IDLE:   if (first_word) state_nx = ST_FETCH;
            ST_FETCH: begin
                if (have_low) begin
                    load     = 1'b1;
                    state_nx = ST_START;
                end else if (!fifo_empty) begin
                    load      = 1'b1;
                    fifo_rd   = 1'b1;
                    load_byte = fifo_rdata[15:8];
                    state_nx  = ST_START;
                end else if (words_left == 8'd0) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_START:  if (tick) state_nx = ST_DATA;
            ST_DATA: begin
                if (tick && (bit_cnt == 3'd7)) begin
`ifdef UART_PARITY_EN
                    state_nx = ST_PARITY;
`else
                    state_nx = ST_STOP;
`endif
                end
            end
            ST_PARITY: if (tick) state_nx = ST_STOP;
            ST_STOP:   if (tick) state_nx = bytes_pending ? ST_FETCH : ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        TX = 1'b1;
        case (state)
            ST_START:  TX = 1'b0;
            ST_DATA:   TX = shreg[0];
            ST_PARITY: TX = par_bit;
            default:   TX = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            low_byte   <= '0;
            words_left <= '0;
            have_low   <= 1'b0;
            len_odd    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state <= state_nx;
            ovf_q <= more_word && !fifo_wr;
            // A dropped word still counts, so the message always terminates
            if (first_word) begin
                words_left <= (MSG_LEN_IN - 8'd1) >> 1;
                len_odd    <= MSG_LEN_IN[0];
            end else if (more_word) begin
                words_left <= words_left - 8'd1;
            end
            if ((state == ST_IDLE) || (state == ST_FETCH)) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
            end
            if ((state == ST_DATA) && tick) bit_cnt <= bit_cnt + 3'd1;
            if (load) begin
                shreg <= load_byte;
            end else if ((state == ST_DATA) && tick) begin
                shreg <= {1'b0, shreg[7:1]};
            end
            if (load) begin
                if (fifo_rd) begin
                    low_byte <= fifo_rdata[7:0];
                    have_low <= !fifo_rdata[16];
                end else begin
                    have_low <= 1'b0;
                end
            end
        end
    end

`ifdef UART_PARITY_EN
    logic parity_odd;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            parity_odd <= 1'b0;
            par_bit    <= 1'b0;
        end else begin
            if (first_word) parity_odd <= PARITY_IN;
            if (load)       par_bit    <= (^load_byte) ^ parity_odd;
        end
    end
`else
    logic unused_parity_in;
    assign unused_parity_in = PARITY_IN;
    assign par_bit          = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer : directed vectors plus serial-line decoder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_serializer;

    localparam int DIV = 8;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] DATA = '0;
    logic        ENA = 1'b0;
    logic [7:0]  MSG_LEN_IN = '0;
    logic        PARITY_IN = 1'b0;
    logic        TX;
    logic        BUSY;
    logic        OVF;

    uart_tx_serializer #(
        .CLK_FREQ   (48000000),
        .BAUD       (6000000),
        .FIFO_DEPTH (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DATA       (DATA),
        .ENA        (ENA),
        .MSG_LEN_IN (MSG_LEN_IN),
        .PARITY_IN  (PARITY_IN),
        .TX         (TX),
        .BUSY       (BUSY),
        .OVF        (OVF)
    );

    always #5 CLK = ~CLK;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] rx_q[$];
    logic       rx_pq[$];
    int         frm_err = 0;
    int         ovf_cnt = 0;
    logic       mon_clr = 1'b0;
    logic       mact = 1'b0;
    int         mcnt = 0;
    int         mbit = 0;
    logic [10:0] mfr = '0;

    // Line decoder: samples each bit in the middle of its period
    always @(negedge CLK) begin
        if (mon_clr) begin
            mact = 1'b0;
        end else if (!mact) begin
            if (TX == 1'b0) begin
                mact = 1'b1;
                mcnt = 0;
                mbit = 0;
            end
        end else begin
            mcnt = mcnt + 1;
            if (mcnt == mbit * DIV + DIV / 2) begin
                mfr[mbit] = TX;
                mbit = mbit + 1;
                if (mbit == FB) begin
                    mact = 1'b0;
                    rx_q.push_back(mfr[8:1]);
                    rx_pq.push_back(mfr[9]);
                    if (mfr[0] != 1'b0 || mfr[FB-1] != 1'b1) frm_err++;
                end
            end
        end
    end

    always @(negedge CLK) if (OVF === 1'b1) ovf_cnt++;

    typedef struct {
        logic [7:0]  len;
        logic        par;
        logic [15:0] w0;
        logic [15:0] w1;
        int          nw;
        int          nexp;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_msg(input vec_t v, input string tag);
        int lat;
        int bend;
        int e0;
        int nb;
        logic [7:0] eb;
        rx_q.delete();
        rx_pq.delete();
        e0 = frm_err;
        @(negedge CLK);
        ENA = 1'b1; DATA = v.w0; MSG_LEN_IN = v.len; PARITY_IN = v.par;
        lat = -1;
        bend = -1;
        for (int k = 1; k <= 4000 && bend < 0; k++) begin
            @(negedge CLK);
            ENA = 1'b0;
            if (k == 1 && v.nw > 1) begin ENA = 1'b1; DATA = v.w1; end
            if (k == 5) begin ENA = 1'b1; DATA = 16'hDEAD; MSG_LEN_IN = 8'd7; end
            if (lat < 0 && TX == 1'b0) lat = k - 1;
            if (BUSY == 1'b0) bend = k - 1;
        end
        ENA = 1'b0; MSG_LEN_IN = 8'd0;
        repeat (DIV) @(negedge CLK);
        chk({tag, "_busy_len"}, bend == v.nexp * (1 + FB * DIV), bend, v.nexp * (1 + FB * DIV));
        chk({tag, "_start_lat"}, lat >= 0 && lat <= 3, lat, 3);
        chk({tag, "_nbytes"}, rx_q.size() == v.nexp, rx_q.size(), v.nexp);
        chk({tag, "_framing"}, frm_err == e0, frm_err - e0, 0);
        nb = (rx_q.size() < v.nexp) ? rx_q.size() : v.nexp;
        for (int i = 0; i < nb; i++) begin
            eb = v.exp[31 - 8*i -: 8];
            chk({tag, "_byte"}, rx_q[i] == eb, int'(rx_q[i]), int'(eb));
`ifdef UART_PARITY_EN
            chk({tag, "_parity"}, rx_pq[i] == ((^eb) ^ v.par), int'(rx_pq[i]), int'((^eb) ^ v.par));
`endif
        end
    endtask

    initial begin
        vec_t rv;
        int   bend;
        int   nbad;

        vecs[0] = '{len: 8'd2, par: 1'b0, w0: 16'hA55A, w1: 16'h0000, nw: 1, nexp: 2, exp: 32'hA55A0000};
        vecs[1] = '{len: 8'd3, par: 1'b1, w0: 16'h0102, w1: 16'h03FF, nw: 2, nexp: 3, exp: 32'h01020300};
        vecs[2] = '{len: 8'd1, par: 1'b0, w0: 16'h07AB, w1: 16'h0000, nw: 1, nexp: 1, exp: 32'h07000000};
        vecs[3] = '{len: 8'd4, par: 1'b1, w0: 16'h8001, w1: 16'hFF00, nw: 2, nexp: 4, exp: 32'h8001FF00};
        vecs[4] = '{len: 8'd1, par: 1'b1, w0: 16'h0700, w1: 16'h0000, nw: 1, nexp: 1, exp: 32'h07000000};

        #3;
        chk("rst_tx", TX == 1'b1, int'(TX), 1);
        chk("rst_busy", BUSY == 1'b0, int'(BUSY), 0);
        chk("rst_ovf", OVF == 1'b0, int'(OVF), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Zero-length request must be ignored
        ENA = 1'b1; DATA = 16'h1234; MSG_LEN_IN = 8'd0;
        @(negedge CLK);
        ENA = 1'b0;
        chk("len0_busy", BUSY == 1'b0, int'(BUSY), 0);
        repeat (3) @(negedge CLK);
        chk("len0_tx", TX == 1'b1, int'(TX), 1);
        chk("len0_nbytes", rx_q.size() == 0, rx_q.size(), 0);

        for (int i = 0; i < 5; i++) run_msg(vecs[i], $sformatf("vec%0d", i));

`ifdef UART_PARITY_EN
        run_msg(vecs[2], "par_even");
        chk("par_even_bit", rx_pq.size() == 1 && rx_pq[0] == 1'b1, int'(rx_pq[0]), 1);
        run_msg(vecs[4], "par_odd");
        chk("par_odd_bit", rx_pq.size() == 1 && rx_pq[0] == 1'b0, int'(rx_pq[0]), 0);
`endif

        // Overflow: 20 words on consecutive cycles into a 16-deep buffer
        rx_q.delete();
        ovf_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            ENA = 1'b1; DATA = {8'(2*i), 8'(2*i+1)}; MSG_LEN_IN = 8'd40; PARITY_IN = 1'b0;
        end
        @(negedge CLK);
        ENA = 1'b0; MSG_LEN_IN = 8'd0;
        bend = -1;
        for (int k = 0; k < 6000 && bend < 0; k++) begin
            @(negedge CLK);
            if (BUSY == 1'b0) bend = k;
        end
        repeat (DIV) @(negedge CLK);
        chk("ovf_busy_clears", bend >= 0, bend, 0);
        chk("ovf_pulses", ovf_cnt >= 3, ovf_cnt, 3);
        chk("ovf_nbytes", rx_q.size() == 40 - 2 * ovf_cnt, rx_q.size(), 40 - 2 * ovf_cnt);
        nbad = 0;
        for (int j = 0; j < rx_q.size(); j++) if (rx_q[j] != 8'(j)) nbad++;
        chk("ovf_order", nbad == 0, nbad, 0);

        // Reset in the middle of the first byte's data bits
        rx_q.delete();
        @(negedge CLK);
        ENA = 1'b1; DATA = 16'hA55A; MSG_LEN_IN = 8'd2;
        @(negedge CLK);
        ENA = 1'b0; MSG_LEN_IN = 8'd0;
        repeat (1 + 4 * DIV) @(negedge CLK);
        chk("mid_busy_pre", BUSY == 1'b1, int'(BUSY), 1);
        #2;
        mon_clr = 1'b1;
        RST = 1'b0;
        #1;
        chk("mid_rst_tx", TX == 1'b1, int'(TX), 1);
        chk("mid_rst_busy", BUSY == 1'b0, int'(BUSY), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        mon_clr = 1'b0;
        repeat (2) @(negedge CLK);
        chk("post_rst_idle", TX == 1'b1 && BUSY == 1'b0, int'(BUSY), 0);
        rv = '{len: 8'd1, par: 1'b0, w0: 16'h3C00, w1: 16'h0000, nw: 1, nexp: 1, exp: 32'h3C000000};
        run_msg(rv, "post_rst");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter CLK_FREQ, default 48000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate; bit period DIV = CLK_FREQ/BAUD cycles (integer division).
REQ-003 Parameter FIFO_DEPTH, default 16, word buffer depth; power of two, at least 4.
REQ-004 CLK  input  1  system clock (ifclk domain); all logic rises on it.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 DATA  input  16  big-endian word from the Cypress read path; bits [15:8] are transmitted first.
REQ-007 ENA  input  1  one-cycle-per-word write strobe; DATA is valid when ENA=1.
REQ-008 MSG_LEN_IN  input  8  payload byte count; sampled on the first ENA of a message.
REQ-009 PARITY_IN  input  1  parity select, 0=even, 1=odd; sampled with MSG_LEN_IN.
REQ-010 TX  output  1  UART line; idle high.
REQ-011 BUSY  output  1  high while a message is loading or transmitting.
REQ-012 OVF  output  1  one-cycle pulse when a word is dropped because the FIFO is full.

Function
REQ-013 In IDLE, ENA=1 with MSG_LEN_IN≠0 shall latch the length and parity, write DATA, and set BUSY on the next edge.
REQ-014 In IDLE, ENA=1 with MSG_LEN_IN=0 shall be ignored: no write, no BUSY.
REQ-015 Words accepted = ceil(len/2); after the last word, further ENA pulses shall be ignored until the message completes.
REQ-016 For odd len, the low byte of the last word shall be discarded.
REQ-017 Byte order shall be DATA[15:8] then DATA[7:0] per word; within each byte, bits go out LSB first.
REQ-018 States: IDLE, FETCH, START, DATA, PARITY, STOP.
REQ-019 FETCH selects the next byte when the FIFO is non-empty, else it waits.
REQ-020 START, DATA×8, PARITY and STOP each last exactly DIV cycles.
REQ-021 The start bit shall appear on TX no later than 3 cycles after the first accepted ENA.
REQ-022 After STOP, go to FETCH while bytes remain, else go to IDLE and drop BUSY on the same edge TX ends the stop bit.
REQ-023 Consecutive bytes shall be back-to-back: no idle gap beyond the FETCH cycle when data is buffered.
REQ-024 ENA while the FIFO is full shall drop the word, pulse OVF, and count the word as consumed so the message still terminates.
REQ-025 A simultaneous FIFO write and read shall both succeed; occupancy stays unchanged.
REQ-026 Baud and bit counters shall wrap to 0 at DIV-1 and 7 respectively; the baud counter width is clog2(DIV).

Reset
REQ-027 On RST=0, immediately: TX=1, BUSY=0, OVF=0, state IDLE, FIFO empty, all counters 0.
REQ-028 Reset mid-frame shall abort the frame; the next message after release shall start cleanly with a full start bit.

Configuration
REQ-029 Macro UART_PARITY_EN defined: frames are 8 data bits, a parity bit (even/odd per latched PARITY_IN), and 1 stop bit.
REQ-030 Macro UART_PARITY_EN undefined: the PARITY state is removed, frames are 8N1, and PARITY_IN is unused.

Structure
REQ-031 The shared defines/package shall hold the state encoding, the DIV computation, and the FIFO_DEPTH default.
REQ-032 The word buffer shall be a sub-module uart_tx_fifo: synchronous, single-clock, with full and empty flags.

Verification (CLK_FREQ=48e6, BAUD=115200, DIV=416)
REQ-033 len=2, word 0xA55A, parity off -> TX bytes 0xA5, 0x5A; each bit 416 cycles; BUSY low after 2×10×416 cycles.
REQ-034 len=3, words 0x0102 and 0x03FF -> bytes 0x01, 0x02, 0x03 only; 0xFF never sent.
REQ-035 UART_PARITY_EN, PARITY_IN=1, byte 0x07 -> parity bit 0 (odd); with PARITY_IN=0 -> parity bit 1.
REQ-036 len=40 (20 words) strobed on consecutive cycles with FIFO_DEPTH=16 -> OVF pulses ≥3 times; BUSY still clears.
REQ-037 RST asserted mid-DATA of byte 1 -> TX=1 and BUSY=0 immediately; a new len=1 message afterwards transmits correctly.
REQ-038 ENA with MSG_LEN_IN=0 in IDLE -> BUSY stays 0 and TX stays 1.
